// File: rtl/deca_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, word
// offsets within the sysid slave, and the 32-bit data word type.
package deca_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    FINISH
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef logic [31:0] sysid_word_t;

endpackage

// File: rtl/deca_sysid_stall_timer.sv
// Loadable down-counter with an expire flag; counts stall cycles against the
// timeout limit and read-latency cycles after command acceptance.
module deca_sysid_stall_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/deca_sysid_checker.sv
// Avalon-MM master that reads sysid word 0 (ID) and word 1 (timestamp) on a
// start request and reports whether both match the expected build image.
module deca_sysid_checker
  import deca_sysid_pkg::*;
#(
  parameter sysid_word_t EXPECTED_ID  = 32'h0000_0000,
  parameter sysid_word_t EXPECTED_TS  = 32'h5537_8FF0,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // The timer is loaded with limit-1 so "expired" marks the final counted cycle.
  localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT - 1);
  localparam logic [15:0] LAT_LOAD = 16'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  sysid_chk_state_t state, state_d;
  logic             tmr_load, tmr_dec, tmr_expired;
  logic [15:0]      tmr_value;
  logic             cap_id, cap_ts, to_hit, accept;
  sysid_word_t      id_d, ts_d;

  deca_sysid_stall_timer #(.WIDTH(16)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .expired    (tmr_expired)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_dec   = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d   = RD_ID;
          tmr_load  = 1'b1;
          tmr_value = TO_LOAD;
        end
      end
      RD_ID, RD_TS: begin
        if (!av_waitrequest) begin
          if (READ_LATENCY == 0) begin
            cap_id    = (state == RD_ID);
            cap_ts    = (state == RD_TS);
            state_d   = (state == RD_ID) ? RD_TS : FINISH;
            tmr_load  = (state == RD_ID);
            tmr_value = TO_LOAD;
          end else begin
            state_d   = (state == RD_ID) ? LAT_ID : LAT_TS;
            tmr_load  = 1'b1;
            tmr_value = LAT_LOAD;
          end
        end else if (tmr_expired) begin
          state_d = FINISH;
          to_hit  = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      LAT_ID: begin
        if (tmr_expired) begin
          cap_id    = 1'b1;
          state_d   = RD_TS;
          tmr_load  = 1'b1;
          tmr_value = TO_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      LAT_TS: begin
        if (tmr_expired) begin
          cap_ts  = 1'b1;
          state_d = FINISH;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The verdict is registered on entry to FINISH so it is valid alongside done.
  always_comb begin
    accept = (state == IDLE) && start;
    id_d   = cap_id ? av_readdata : id_value;
    ts_d   = cap_ts ? av_readdata : ts_value;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      av_read     <= 1'b0;
      av_address  <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state      <= state_d;
      av_read    <= (state_d == RD_ID) || (state_d == RD_TS);
      av_address <= ((state_d == RD_TS) || (state_d == LAT_TS)) ? SYSID_ADDR_TS
                                                                 : SYSID_ADDR_ID;
      busy       <= (state_d != IDLE);
      done       <= (state_d == FINISH);
      if (accept) begin
        pass        <= 1'b0;
        timeout_err <= 1'b0;
        id_value    <= '0;
        ts_value    <= '0;
      end else begin
        id_value <= id_d;
        ts_value <= ts_d;
        if (to_hit) begin
          timeout_err <= 1'b1;
          pass        <= 1'b0;
        end else if (state_d == FINISH) begin
          pass <= (id_d == EXPECTED_ID) && (ts_d == EXPECTED_TS);
        end
      end
    end
  end

endmodule

// File: tb/tb_deca_sysid_checker.sv
// Directed bench: dut_a (latency 0, timeout 4) runs a vector table; dut_b
// (latency 2, 5 wait states per read) covers stalls and reset mid-read.
module tb_deca_sysid_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        start_a = 1'b0, wr_a = 1'b0;
  logic [31:0] slv_id_a = '0, slv_ts_a = '0, rd_a;
  logic        read_a, addr_a, busy_a, done_a, pass_a, to_a;
  logic [31:0] idv_a, tsv_a;

  logic        start_b = 1'b0, wr_b;
  logic [31:0] slv_id_b = 32'h0000_0000, slv_ts_b = 32'h5537_8FF0, rd_b;
  logic        read_b, addr_b, busy_b, done_b, pass_b, to_b;
  logic [31:0] idv_b, tsv_b;

  int checks = 0, failures = 0;
  int done_cnt_a = 0, done_cnt_b = 0, stall_seen = 0, stall_bad = 0;

  always #5 clock = ~clock;

  deca_sysid_checker #(.READ_LATENCY(0), .TIMEOUT(4)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .av_address(addr_a),
    .av_read(read_a), .av_waitrequest(wr_a), .av_readdata(rd_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout_err(to_a),
    .id_value(idv_a), .ts_value(tsv_a));

  deca_sysid_checker #(.READ_LATENCY(2), .TIMEOUT(255)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .av_address(addr_b),
    .av_read(read_b), .av_waitrequest(wr_b), .av_readdata(rd_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout_err(to_b),
    .id_value(idv_b), .ts_value(tsv_b));

  // Slave A: zero latency, waitrequest under direct bench control.
  assign rd_a = addr_a ? slv_ts_a : slv_id_a;

  // Slave B: 5 wait states per read, data valid 2 cycles after acceptance.
  logic [3:0] wcnt;
  logic       p1v, p2v, p1a, p2a;
  assign wr_b = read_b && (wcnt < 4'd5);
  assign rd_b = p2v ? (p2a ? slv_ts_b : slv_id_b) : 32'hDEAD_BEEF;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt <= '0; p1v <= 1'b0; p2v <= 1'b0; p1a <= 1'b0; p2a <= 1'b0;
    end else begin
      if (read_b && wr_b) wcnt <= wcnt + 4'd1;
      else if (read_b)    wcnt <= '0;
      p1v <= read_b && !wr_b;
      p1a <= addr_b;
      p2v <= p1v;
      p2a <= p1a;
    end
  end

  // Done-pulse counters and stall-stability monitor on dut_b.
  logic prev_stall = 1'b0, prev_addr = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (done_b) done_cnt_b <= done_cnt_b + 1;
      if (prev_stall && (!read_b || addr_b != prev_addr)) stall_bad <= stall_bad + 1;
      if (read_b && wr_b) stall_seen <= stall_seen + 1;
    end
    prev_stall <= !reset && read_b && wr_b;
    prev_addr  <= addr_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    logic        stuck;
    int          exp_lat;
    logic        exp_pass;
    logic        exp_to;
    logic [31:0] exp_id;
    logic [31:0] exp_ts;
  } vec_t;

  vec_t vecs[6];

  task automatic run_a(input vec_t v, input int idx);
    int lat;
    slv_id_a = v.id_word;
    slv_ts_a = v.ts_word;
    wr_a     = v.stuck;
    @(negedge clock); start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
    lat = 1;
    while (!done_a && lat < 40) begin
      @(negedge clock); lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_pass", idx), pass_a, v.exp_pass);
    check($sformatf("v%0d_timeout_err", idx), to_a, v.exp_to);
    check($sformatf("v%0d_id_value", idx), idv_a, v.exp_id);
    check($sformatf("v%0d_ts_value", idx), tsv_a, v.exp_ts);
    check($sformatf("v%0d_read_at_done", idx), read_a, 1'b0);
    @(negedge clock);
    check($sformatf("v%0d_busy_after", idx), busy_a, 1'b0);
    check($sformatf("v%0d_done_after", idx), done_a, 1'b0);
    wr_a = 1'b0;
  endtask

  task automatic run_b(input string tag);
    int lat;
    @(negedge clock); start_b = 1'b1;
    @(negedge clock); start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 60) begin
      @(negedge clock); lat++;
    end
    check({tag, "_latency"}, lat, 17);
    check({tag, "_pass"}, pass_b, 1'b1);
    check({tag, "_timeout_err"}, to_b, 1'b0);
    check({tag, "_id_value"}, idv_b, 32'h0000_0000);
    check({tag, "_ts_value"}, tsv_b, 32'h5537_8FF0);
  endtask

  initial begin
    int snap;
    vecs[0] = '{32'h0000_0000, 32'h5537_8FF0, 1'b0, 3, 1'b1, 1'b0, 32'h0000_0000, 32'h5537_8FF0};
    vecs[1] = '{32'h0000_0000, 32'h5537_8FF1, 1'b0, 3, 1'b0, 1'b0, 32'h0000_0000, 32'h5537_8FF1};
    vecs[2] = '{32'h0000_0001, 32'h5537_8FF0, 1'b0, 3, 1'b0, 1'b0, 32'h0000_0001, 32'h5537_8FF0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 3, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000};
    vecs[4] = '{32'h0000_0000, 32'h5537_8FF0, 1'b1, 5, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'h0000_0000, 32'h5537_8FF0, 1'b0, 3, 1'b1, 1'b0, 32'h0000_0000, 32'h5537_8FF0};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_av_read", read_a, 1'b0);
    check("rst_av_address", addr_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_pass", pass_a, 1'b0);
    check("rst_timeout_err", to_a, 1'b0);
    check("rst_id_value", idv_a, 32'h0);
    check("rst_ts_value", tsv_a, 32'h0);
    check("rst_b_busy", busy_b, 1'b0);

    for (int i = 0; i < 6; i++) run_a(vecs[i], i);

    // Start re-pulsed during RD_TS and FINISH must be dropped.
    slv_id_a = 32'h0000_0000;
    slv_ts_a = 32'h5537_8FF0;
    snap = done_cnt_a;
    @(negedge clock); start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
    check("seq_c1_read", read_a, 1'b1);
    check("seq_c1_addr", addr_a, 1'b0);
    check("seq_c1_busy", busy_a, 1'b1);
    @(negedge clock); start_a = 1'b1;
    check("seq_c2_read", read_a, 1'b1);
    check("seq_c2_addr", addr_a, 1'b1);
    @(negedge clock);
    check("seq_c3_done", done_a, 1'b1);
    @(negedge clock); start_a = 1'b0;
    check("seq_c4_busy", busy_a, 1'b0);
    repeat (6) @(negedge clock);
    check("seq_done_pulses", done_cnt_a - snap, 1);
    check("seq_idle_busy", busy_a, 1'b0);
    check("seq_pass", pass_a, 1'b1);

    // Stalled reads with read latency 2.
    snap = stall_seen;
    run_b("stall");
    repeat (2) @(negedge clock);
    check("stall_cycles_seen", stall_seen - snap, 10);
    check("stall_cmd_stable", stall_bad, 0);

    // Reset asserted while dut_b sits in LAT_ID (cycles 7-8 after start).
    @(negedge clock); start_b = 1'b1;
    @(negedge clock); start_b = 1'b0;
    repeat (6) @(negedge clock);
    check("lat_read_low", read_b, 1'b0);
    check("lat_busy", busy_b, 1'b1);
    snap = done_cnt_b;
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_b_busy", busy_b, 1'b0);
    check("mid_rst_b_read", read_b, 1'b0);
    check("mid_rst_b_done", done_b, 1'b0);
    check("mid_rst_a_pass", pass_a, 1'b0);
    check("mid_rst_a_ts_value", tsv_a, 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("mid_rst_no_done", done_cnt_b - snap, 0);
    check("mid_rst_b_pass", pass_b, 1'b0);
    run_b("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deca_sysid_checker.md
# deca_sysid_checker

Avalon-MM master that reads the two words of the system-ID slave (word 0 = system ID, word 1 = build timestamp) on a start request. It compares both against expected values and reports pass/fail plus the captured words. It sits directly downstream of the sysid slave, on the same interconnect, and gates boot-time release logic (e.g. Nios reset release or a status LED) on a verified hardware image.

## Interface
- EXPECTED_ID, 32'h0000_0000, value required at word 0
- EXPECTED_TS, 32'h5537_8FF0, value required at word 1 (1429704688)
- READ_LATENCY, 0, fixed slave read latency in cycles after command acceptance; legal range 0..3
- TIMEOUT, 255, max cycles `av_read` may be stalled by `av_waitrequest` per read; legal range 1..65535
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run a check; ignored while busy
- av_address  out  1  word select: 0 = ID, 1 = timestamp
- av_read  out  1  read command
- av_waitrequest  in  1  slave stall
- av_readdata  in  32  slave read data
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at completion (pass, fail or timeout)
- pass  out  1  sticky result: both words matched
- timeout_err  out  1  sticky: a read exceeded TIMEOUT
- id_value  out  32  captured word 0
- ts_value  out  32  captured word 1

## Operation
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FINISH.
- IDLE: `start`=1 -> RD_ID. At the same edge, clear `pass`, `timeout_err`, `id_value` and `ts_value`.
- RD_ID: `av_read`=1, `av_address`=0, both held stable while `av_waitrequest`=1.
  - Command accepted when `av_waitrequest`=0.
  - READ_LATENCY=0: capture `av_readdata` into `id_value` in the accept cycle and go to RD_TS.
  - READ_LATENCY>0: go to LAT_ID.
- LAT_ID: `av_read`=0. Count READ_LATENCY cycles; capture on the last one, then go to RD_TS.
- RD_TS / LAT_TS: identical to RD_ID / LAT_ID with `av_address`=1, capturing into `ts_value`, then go to FINISH.
- FINISH: `done`=1 for one cycle. `pass` = (`id_value`==EXPECTED_ID) && (`ts_value`==EXPECTED_TS). Next state is IDLE.
- Timeout: a per-read stall counter increments each cycle in RD_* with `av_waitrequest`=1 and clears when leaving RD_*. On reaching TIMEOUT, go straight to FINISH with `timeout_err`=1 and `pass` forced 0; `av_read` drops the following cycle.
- `start` arriving during busy is dropped, not queued. A `start` in the FINISH cycle is also dropped.
- Comparison is full 32-bit equality, with no masking.

## Timing
- Reset values: `av_read`=0, `av_address`=0, `busy`=0, `done`=0, `pass`=0, `timeout_err`=0, `id_value`=0, `ts_value`=0, state=IDLE.
- All outputs are registered.
- `busy` rises the cycle after `start` and falls the cycle after FINISH.
- Zero-wait, READ_LATENCY=0, `start` at cycle 0:
  - `av_read`/address 0 at cycle 1
  - `av_read`/address 1 at cycle 2
  - `done` at cycle 3
- General latency = 3 + 2·READ_LATENCY + total wait cycles.
- Reset mid-operation: immediate return to reset values; any in-flight read is abandoned, with no `done` pulse.
- `pass` and `timeout_err` hold until the next accepted `start` or reset.

## Structure
- Shared package `deca_sysid_pkg`:
  - state enum `sysid_chk_state_t`
  - word-offset constants `SYSID_ADDR_ID`=0 and `SYSID_ADDR_TS`=1
  - a 32-bit `sysid_word_t` typedef
- One natural sub-module, `deca_sysid_stall_timer`: a loadable down-counter with an expire flag, used for both the stall timeout and the read-latency count.

## Test plan
- Matching slave (ID 0, TS 0x55378FF0), no waits, READ_LATENCY=0 -> `done` at cycle 3, `pass`=1, `id_value`=0, `ts_value`=0x55378FF0.
- Slave returns TS 0x55378FF1 -> `done`, `pass`=0, `timeout_err`=0, `ts_value`=0x55378FF1.
- `av_waitrequest` held 5 cycles on each read, READ_LATENCY=2 -> `done` at cycle 17, `pass`=1; address and `av_read` stable throughout each stall.
- TIMEOUT=4, `av_waitrequest` stuck high -> `done` 5 cycles after `start`, `timeout_err`=1, `pass`=0, `av_read`=0 afterwards.
- `start` pulsed again during RD_TS and during FINISH -> ignored; exactly one `done` pulse.
- `reset` asserted during LAT_ID -> all outputs return to reset values next edge, no `done`; a later `start` runs a clean check with `pass`=1.
